data_sampling_mv: RTL

DATA_SAMPLING_MV -- requirements
Module: data_sampling_mv

---
 rtl/data_sampling_mv.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/data_sampling_mv.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : data_sampling_mv
//  Purpose  : Majority-vote bit sampler for an oversampled serial receiver.
//             NUM_SAMPLES consecutive oversamples centred on the middle of
//             each bit period are voted. The decision is published with a
//             one-cycle DONE pulse on the edge after the last sample.
//  Options  : Define DATA_SAMPLING_NOISE_EN to build the noise detector.
//             When it is undefined, noise_flag is tied low.
//  Revision : 1.0  initial release
// ============================================================================
module data_sampling_mv #(
    parameter int PRESCALE_W  = 6,
    parameter int NUM_SAMPLES = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic                  sampled_bit,
    output logic                  DONE,
    output logic                  noise_flag
);

    // Window arithmetic uses one extra bit so that E and D cannot wrap.
    localparam int                c_ONES_W    = $clog2(NUM_SAMPLES + 1);
    localparam int                c_EXT_W     = PRESCALE_W + 1;
    localparam logic [c_EXT_W-1:0]  c_HALF      = c_EXT_W'((NUM_SAMPLES - 1) / 2);
    localparam logic [c_EXT_W-1:0]  c_SPAN      = c_EXT_W'(NUM_SAMPLES - 1);
    localparam logic [c_ONES_W-1:0] c_NUM       = c_ONES_W'(NUM_SAMPLES);
    localparam logic [c_ONES_W-1:0] c_HALF_ONES = c_ONES_W'((NUM_SAMPLES - 1) / 2);

    // State registers
    logic [c_ONES_W-1:0] ones_q, ones_d;
    logic                sample_q, sample_d;
    logic                armed_q, armed_d;
    logic                bit_q, bit_d;
    logic                done_q, done_d;

    // Window geometry derived from Prescale
    logic [c_EXT_W-1:0] w_edge_ext;
    logic [c_EXT_W-1:0] w_center;
    logic [c_EXT_W-1:0] w_start;
    logic [c_EXT_W-1:0] w_end;
    logic [c_EXT_W-1:0] w_decide;
    logic               w_edge_legal;
    logic               w_in_window;
    logic               w_at_start;
    logic               w_take;
    logic               w_at_decide;
    logic               w_vote;

    assign w_edge_ext   = {1'b0, edge_cnt};
    assign w_center     = {1'b0, Prescale} >> 1;
    assign w_start      = (w_center > c_HALF) ? (w_center - c_HALF) : '0;
    assign w_end        = w_start + c_SPAN;
    assign w_decide     = w_end + c_EXT_W'(1);

    // Edge indices at or beyond Prescale are not part of the bit period.
    assign w_edge_legal = (edge_cnt < Prescale);
    assign w_in_window  = enable && w_edge_legal &&
                          (w_edge_ext >= w_start) && (w_edge_ext <= w_end);
    assign w_at_start   = w_in_window && (w_edge_ext == w_start);

    // A window only counts if it was entered at its first sample; this keeps
    // a window that was cut by reset from producing a partial vote.
    assign w_take       = w_in_window && (armed_q || w_at_start);
    assign w_at_decide  = enable && w_edge_legal && armed_q &&
                          (w_edge_ext == w_decide);
    assign w_vote       = (ones_q > c_HALF_ONES);

    // Next-state logic for the vote counter, window tracking and decision.
    always_comb begin
        ones_d   = ones_q;
        sample_d = sample_q;
        armed_d  = armed_q;
        bit_d    = bit_q;
        done_d   = 1'b0;
        if (!enable) begin
            ones_d  = '0;
            armed_d = 1'b0;
        end else if (w_take) begin
            sample_d = RX_IN;
            armed_d  = 1'b1;
            if (w_at_start) begin
                // Starting afresh also recovers from a window that never
                // reached its decision edge because Prescale was too small.
                ones_d = c_ONES_W'(RX_IN);
            end else if (RX_IN && (ones_q != c_NUM)) begin
                ones_d = ones_q + c_ONES_W'(1);
            end
        end else if (w_at_decide) begin
            done_d  = 1'b1;
            bit_d   = w_vote;
            ones_d  = '0;
            armed_d = 1'b0;
        end
    end

    // Register all sampler state; reset clears everything asynchronously.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ones_q   <= '0;
            sample_q <= 1'b0;
            armed_q  <= 1'b0;
            bit_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            ones_q   <= ones_d;
            sample_q <= sample_d;
            armed_q  <= armed_d;
            bit_q    <= bit_d;
            done_q   <= done_d;
        end
    end

    assign sampled_bit = bit_q;
    assign DONE        = done_q;

    // The last captured sample is retained as state but not used by the vote.
    logic w_unused;
    assign w_unused = sample_q;

`ifdef DATA_SAMPLING_NOISE_EN
    logic noise_q, noise_d;

    // Flag a decision whose samples disagreed; hold it until the next one.
    always_comb begin
        noise_d = noise_q;
        if (w_at_decide) begin
            noise_d = (ones_q != '0) && (ones_q != c_NUM);
        end
    end

    // Register the noise indication.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            noise_q <= 1'b0;
        end else begin
            noise_q <= noise_d;
        end
    end

    assign noise_flag = noise_q;
`else
    assign noise_flag = 1'b0;
`endif

endmodule
`default_nettype wire
